// File: rtl/key_debounce_ext.sv
// key_debounce_ext: N-channel key debouncer with press/release
// debounce, long-press and auto-repeat events per channel.
module key_debounce_ext #(
    parameter int N          = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_NUM    = 240000,
    parameter int WIDTH      = 18,
    parameter int LONG_NUM   = 24000000,
    parameter int REPEAT_NUM = 4800000,
    parameter int HWIDTH     = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] key_in,
    input  logic [N-1:0] repeat_en,
    output logic [N-1:0] key_state,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_pulse,
    output logic [N-1:0] repeat_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    localparam logic REL = (ACTIVE_LOW != 0);
    localparam logic [WIDTH-1:0]  CNT_LAST  = WIDTH'(CNT_NUM - 1);
    localparam logic [HWIDTH-1:0] LONG_LAST = HWIDTH'(LONG_NUM - 1);
    localparam logic [HWIDTH-1:0] REP_LAST  = HWIDTH'(REPEAT_NUM - 1);

    logic [N-1:0] sync1;
    logic [N-1:0] sync2;
    logic [N-1:0] kp;

    // Two-flop synchroniser, parked at the released level in reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= {N{REL}};
            sync2 <= {N{REL}};
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign kp = REL ? ~sync2 : sync2;

    for (genvar g = 0; g < N; g++) begin : g_ch
        state_t            state, state_nx;
        logic [WIDTH-1:0]  cnt, cnt_nx;
        logic [HWIDTH-1:0] hcnt, hcnt_nx;
        logic              long_done, long_done_nx;
        logic              ks, ks_nx;
        logic              prs, prs_nx;
        logic              rls, rls_nx;
        logic              lng, lng_nx;
        logic              rpt, rpt_nx;
        logic              hold_adv;

        // Channel state, counters and registered event outputs
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                hcnt      <= '0;
                long_done <= 1'b0;
                ks        <= 1'b0;
                prs       <= 1'b0;
                rls       <= 1'b0;
                lng       <= 1'b0;
                rpt       <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                hcnt      <= hcnt_nx;
                long_done <= long_done_nx;
                ks        <= ks_nx;
                prs       <= prs_nx;
                rls       <= rls_nx;
                lng       <= lng_nx;
                rpt       <= rpt_nx;
            end
        end

        // Next state; a return from a release glitch advances the
        // hold count that same cycle so the delay equals the glitch
        always_comb begin
            state_nx     = state;
            cnt_nx       = cnt;
            hcnt_nx      = hcnt;
            long_done_nx = long_done;
            ks_nx        = ks;
            prs_nx       = 1'b0;
            rls_nx       = 1'b0;
            lng_nx       = 1'b0;
            rpt_nx       = 1'b0;
            hold_adv     = 1'b0;
            unique case (state)
                IDLE: begin
                    ks_nx = 1'b0;
                    if (kp[g]) begin
                        state_nx = PRESS_WAIT;
                        cnt_nx   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!kp[g]) begin
                        state_nx = IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state_nx     = PRESSED;
                        prs_nx       = 1'b1;
                        ks_nx        = 1'b1;
                        hcnt_nx      = '0;
                        long_done_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt + WIDTH'(1);
                    end
                end
                PRESSED, REPEAT: begin
                    if (!kp[g]) begin
                        state_nx = RELEASE_WAIT;
                        cnt_nx   = '0;
                    end else begin
                        hold_adv = 1'b1;
                    end
                end
                RELEASE_WAIT: begin
                    if (kp[g]) begin
                        hold_adv = 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state_nx = IDLE;
                        rls_nx   = 1'b1;
                        ks_nx    = 1'b0;
                    end else begin
                        cnt_nx = cnt + WIDTH'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
            if (hold_adv) begin
                if (!long_done) begin
                    if (hcnt == LONG_LAST) begin
                        state_nx     = REPEAT;
                        lng_nx       = 1'b1;
                        hcnt_nx      = '0;
                        long_done_nx = 1'b1;
                    end else begin
                        state_nx = PRESSED;
                        hcnt_nx  = hcnt + HWIDTH'(1);
                    end
                end else begin
                    state_nx = REPEAT;
                    if (hcnt == REP_LAST) begin
                        hcnt_nx = '0;
                        rpt_nx  = repeat_en[g];
                    end else begin
                        hcnt_nx = hcnt + HWIDTH'(1);
                    end
                end
            end
        end

        assign key_state[g]     = ks;
        assign press_pulse[g]   = prs;
        assign release_pulse[g] = rls;
        assign long_pulse[g]    = lng;
        assign repeat_pulse[g]  = rpt;
    end

endmodule

// File: tb/tb_key_debounce_ext.sv
// tb_key_debounce_ext: scoreboard bench for key_debounce_ext.
// Expected pulse vectors are queued by cycle and checked each cycle.
module tb_key_debounce_ext;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_in;
    logic [N-1:0] repeat_en;
    logic [N-1:0] key_state;
    logic [N-1:0] press_pulse;
    logic [N-1:0] release_pulse;
    logic [N-1:0] long_pulse;
    logic [N-1:0] repeat_pulse;

    key_debounce_ext #(
        .N          (4),
        .ACTIVE_LOW (1),
        .CNT_NUM    (8),
        .WIDTH      (4),
        .LONG_NUM   (32),
        .REPEAT_NUM (10),
        .HWIDTH     (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .repeat_en     (repeat_en),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [15:0] vec;
    } ev_t;

    ev_t sb[$];
    int  n_run  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;

    // vec layout: [3:0] press, [7:4] release, [11:8] long, [15:12] repeat
    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int at, input logic [15:0] vec);
        ev_t e;
        e.at  = at;
        e.vec = vec;
        sb.push_back(e);
    endtask

    // Compare the pulse outputs every cycle against the queued events
    always @(negedge clk) begin
        logic [15:0] e;
        e = '0;
        if (mon_en) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].at == cyc) begin
                    e |= sb[i].vec;
                    sb.delete(i);
                end
            end
            chk("pulses",
                {16'h0, repeat_pulse, long_pulse, release_pulse, press_pulse},
                {16'h0, e});
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int c;
        int p;
        rst_n     = 1'b0;
        key_in    = 4'b0000;
        repeat_en = 4'b0000;

        // reset with all keys held
        @(negedge clk);
        mon_en = 1'b1;
        chk("rst_state0", {28'h0, key_state}, 32'h0);
        wait_n(2);
        chk("rst_state1", {28'h0, key_state}, 32'h0);
        rst_n = 1'b1;
        c = cyc;
        push(c + 11, 16'h000F);
        wait_n(13);
        chk("all_pressed", {28'h0, key_state}, 32'hF);
        key_in = 4'hF;
        c = cyc;
        push(c + 11, 16'h00F0);
        wait_n(14);
        chk("all_released", {28'h0, key_state}, 32'h0);

        // bounce on key 0
        for (int i = 0; i < 40; i++) begin
            key_in[0] = ((i / 3) % 2) == 1;
            @(negedge clk);
        end
        key_in[0] = 1'b1;
        wait_n(20);
        chk("bounce_state", {28'h0, key_state}, 32'h0);

        // reset while key 1 is debouncing, then full re-debounce
        key_in[1] = 1'b0;
        wait_n(5);
        rst_n = 1'b0;
        wait_n(2);
        chk("midrst_state", {28'h0, key_state}, 32'h0);
        rst_n = 1'b1;
        c = cyc;
        push(c + 11, 16'h0002);
        wait_n(15);
        chk("midrst_press", {28'h0, key_state}, 32'h2);
        key_in[1] = 1'b1;
        c = cyc;
        push(c + 11, 16'h0020);
        wait_n(15);
        chk("midrst_rel", {28'h0, key_state}, 32'h0);

        // clean press on key 1
        key_in[1] = 1'b0;
        c = cyc;
        push(c + 11, 16'h0002);
        wait_n(20);
        chk("clean_state", {28'h0, key_state}, 32'h2);
        key_in[1] = 1'b1;
        c = cyc;
        push(c + 11, 16'h0020);
        wait_n(15);
        chk("clean_rel", {28'h0, key_state}, 32'h0);

        // long press and auto-repeat on key 2
        repeat_en = 4'b0100;
        key_in[2] = 1'b0;
        c = cyc;
        p = c + 11;
        push(p, 16'h0004);
        push(p + 32, 16'h0400);
        push(p + 42, 16'h4000);
        push(p + 52, 16'h4000);
        wait_n(66);
        chk("rep_state", {28'h0, key_state}, 32'h4);
        key_in[2] = 1'b1;
        push(cyc + 11, 16'h0040);
        wait_n(15);

        // long press with repeat disabled
        repeat_en = 4'b0000;
        key_in[2] = 1'b0;
        c = cyc;
        p = c + 11;
        push(p, 16'h0004);
        push(p + 32, 16'h0400);
        wait_n(66);
        key_in[2] = 1'b1;
        push(cyc + 11, 16'h0040);
        wait_n(15);

        // release glitch at hcnt=20 delays long_pulse by 4
        key_in[2] = 1'b0;
        c = cyc;
        p = c + 11;
        push(p, 16'h0004);
        wait_n(30);
        key_in[2] = 1'b1;
        wait_n(4);
        chk("glitch_state", {28'h0, key_state}, 32'h4);
        key_in[2] = 1'b0;
        push(p + 36, 16'h0400);
        wait_n(17);
        key_in[2] = 1'b1;
        push(cyc + 11, 16'h0040);
        wait_n(15);
        chk("glitch_rel", {28'h0, key_state}, 32'h0);

        // simultaneous press on keys 0 and 3
        key_in = 4'b0110;
        c = cyc;
        push(c + 11, 16'h0009);
        wait_n(13);
        chk("simul_state", {28'h0, key_state}, 32'h9);
        key_in = 4'b1111;
        push(cyc + 11, 16'h0090);
        wait_n(15);
        chk("simul_rel", {28'h0, key_state}, 32'h0);

        wait_n(5);
        mon_en = 1'b0;
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
